// File: rtl/switch_allocator.sv
// Per-cycle round-robin switch allocator for a 5-port mesh router (N,S,E,W,L).
// Grants, crossbar selects and FIFO pops are combinational; only the pointers and drop counter are registered.
module switch_allocator #(
  parameter logic [4:0]  PORT_MASK = 5'b11111,
  parameter int unsigned ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       req_valid_i,
  input  logic [14:0]      req_dest_i,
  input  logic [4:0]       out_full_i,
  output logic [14:0]      port_select_o,
  output logic [4:0]       port_enable_o,
  output logic [4:0]       port_remove_o,
  output logic [ERR_W-1:0] drop_cnt_o
);
  localparam int         NP       = 5;
  localparam logic [2:0] SEL_NONE = 3'd7;
  localparam logic [7:0] MASK8    = {3'b000, PORT_MASK};

  logic [2:0]       ptr_q [NP];
  logic [2:0]       ptr_d [NP];
  logic [ERR_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [2:0]    dest [NP];
  logic [NP-1:0] eligible;
  logic [NP-1:0] bad;
  logic [NP-1:0] grant_en;
  logic [2:0]    grant_sel [NP];
  logic [NP-1:0] grant_rem;

  // Only valid, present inputs look at their destination, so X on idle inputs stays contained.
  always_comb begin : classify
    for (int i = 0; i < NP; i++) begin
      dest[i]     = req_dest_i[3*i +: 3];
      eligible[i] = 1'b0;
      bad[i]      = 1'b0;
      if (req_valid_i[i] && PORT_MASK[i]) begin
        if (dest[i] > 3'd4 || !MASK8[dest[i]]) begin
          bad[i] = 1'b1;
        end else if (!out_full_i[dest[i]]) begin
          eligible[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin : arbitrate
    logic [3:0] sum;
    logic [2:0] idx;
    logic       found;
    grant_rem = bad;
    for (int o = 0; o < NP; o++) begin
      grant_en[o]  = 1'b0;
      grant_sel[o] = SEL_NONE;
      ptr_d[o]     = ptr_q[o];
      found        = 1'b0;
      for (int k = 0; k < NP; k++) begin
        sum = {1'b0, ptr_q[o]} + 4'(k);
        idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
        if (!found && eligible[idx] && dest[idx] == 3'(o)) begin
          found          = 1'b1;
          grant_en[o]    = 1'b1;
          grant_sel[o]   = idx;
          grant_rem[idx] = 1'b1;
          ptr_d[o]       = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        end
      end
    end
  end

  always_comb begin : drop_count
    logic [ERR_W+2:0] total;
    total = {3'b000, drop_cnt_q};
    for (int i = 0; i < NP; i++) begin
      total = total + {{(ERR_W+2){1'b0}}, bad[i]};
    end
    if (total > {3'b000, {ERR_W{1'b1}}}) begin
      drop_cnt_d = '1;
    end else begin
      drop_cnt_d = total[ERR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < NP; o++) begin
        ptr_q[o] <= '0;
      end
      drop_cnt_q <= '0;
    end else begin
      for (int o = 0; o < NP; o++) begin
        ptr_q[o] <= ptr_d[o];
      end
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Reset gates the combinational outputs directly so they drop without waiting for a clock.
  always_comb begin : drive_outputs
    port_select_o = {NP{SEL_NONE}};
    port_enable_o = '0;
    port_remove_o = '0;
    if (rst) begin
      for (int o = 0; o < NP; o++) begin
        port_select_o[3*o +: 3] = grant_sel[o];
      end
      port_enable_o = grant_en;
      port_remove_o = grant_rem;
    end
  end

  assign drop_cnt_o = drop_cnt_q;

endmodule
